// File: rtl/hft_pkg.sv
// Shared scheduler types and defaults: FSM state encoding, queue/timeout defaults, operand widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.

// Vertex/weight width macros normally arrive from Const.vh; defaults here keep the slice self-contained.
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

package hft_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PULSE  = 3'd2,
        WAIT   = 3'd3,
        RETIRE = 3'd4,
        ERROR  = 3'd5
    } sched_state_t;

    localparam int DEPTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 65535;

    localparam int PRED_W    = `PRED_WIDTH + 1;
    localparam int WEIGHT_W  = `WEIGHT_WIDTH + 1;
    localparam int ENTRY_W   = 2 * PRED_W + WEIGHT_W;
    localparam int RUN_CNT_W = 16;

endpackage

// File: rtl/upd_fifo.sv
// Synchronous update queue: register-array storage, occupancy-count derived empty/full flags.
// Latency: a push is visible at the head and in the flags on the cycle after the accepting edge.
// Backpressure: full is exported; pushes while full and pops while empty are ignored internally.

module upd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage is data-only and needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flags registered from the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/update_scheduler.sv
// Queues edge updates and runs the Container once per update: load operands, pulse reset, await done.
// Latency: container_reset rises 3 cycles after an update is accepted into an empty, idle scheduler.
// Backpressure: upd_ready drops when the queue is full or after a timeout error (sticky until reset).

module update_scheduler
    import hft_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [`PRED_WIDTH:0]     upd_src,
    input  logic [`PRED_WIDTH:0]     upd_dst,
    input  logic [`WEIGHT_WIDTH:0]   upd_e,
    input  logic [`PRED_WIDTH:0]     cfg_src,
    output logic                     container_reset,
    output logic [`PRED_WIDTH:0]     src,
    output logic [`PRED_WIDTH:0]     u_src,
    output logic [`PRED_WIDTH:0]     u_dst,
    output logic [`WEIGHT_WIDTH:0]   u_e,
    input  logic                     container_done,
    output logic                     busy,
    output logic [15:0]              run_count,
    output logic                     err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t         state;
    logic [ENTRY_W-1:0]   head_dat;
    logic                 q_empty;
    logic                 q_full;
    logic                 push;
    logic                 pop;
    logic                 wait_first;
    logic [TW-1:0]        tmo_cnt;
    logic [RUN_CNT_W-1:0] run_cnt_q;

    assign upd_ready = !q_full && !err;
    assign push      = upd_valid && upd_ready;
    assign pop       = (state == LOAD);
    assign run_count = run_cnt_q;

    upd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({upd_src, upd_dst, upd_e}),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (q_empty),
        .full     (q_full)
    );

    // Run sequencer: all outputs registered; the reset pulse lands in WAIT's first cycle,
    // which is why done is ignored there (it may still be left over from the previous run).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            container_reset <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b0;
            run_cnt_q       <= '0;
            src             <= '0;
            u_src           <= '0;
            u_dst           <= '0;
            u_e             <= '0;
            wait_first      <= 1'b0;
            tmo_cnt         <= '0;
        end else begin
            container_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    src                  <= cfg_src;
                    {u_src, u_dst, u_e}  <= head_dat;
                    state                <= PULSE;
                end
                PULSE: begin
                    container_reset <= 1'b1;
                    wait_first      <= 1'b1;
                    tmo_cnt         <= '0;
                    state           <= WAIT;
                end
                WAIT: begin
                    wait_first <= 1'b0;
                    if (container_done && !wait_first) begin
                        state <= RETIRE;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RETIRE: begin
                    run_cnt_q <= run_cnt_q + RUN_CNT_W'(1);
                    if (!q_empty) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_update_scheduler.sv
// Self-checking bench for update_scheduler: directed table runs, burst/order, random scoreboard, reset, timeout.
// Latency: n/a.
// Backpressure: n/a.

module tb_update_scheduler;
    import hft_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 50;

    logic                clk = 1'b0;
    logic                reset;
    logic                upd_valid;
    logic                upd_ready;
    logic [PRED_W-1:0]   upd_src, upd_dst, cfg_src, src, u_src, u_dst;
    logic [WEIGHT_W-1:0] upd_e, u_e;
    logic                container_reset, container_done, busy, err;
    logic [15:0]         run_count;

    always #5 clk = ~clk;

    update_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_src(upd_src), .upd_dst(upd_dst), .upd_e(upd_e), .cfg_src(cfg_src),
        .container_reset(container_reset), .src(src), .u_src(u_src), .u_dst(u_dst),
        .u_e(u_e), .container_done(container_done), .busy(busy),
        .run_count(run_count), .err(err)
    );

    typedef struct packed {
        logic [PRED_W-1:0]   s;
        logic [PRED_W-1:0]   d;
        logic [WEIGHT_W-1:0] e;
    } upd_t;

    typedef struct {
        logic [PRED_W-1:0]   s, d, c;
        logic [WEIGHT_W-1:0] e;
        int                  delay;
        bit                  preload;
        logic [15:0]         exp_count;
    } row_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_runs = 16'd0;
    upd_t        sb[$];
    int          cyc = 0;
    int          retire_at = -1;
    int          acc_count = 0;
    int          pulse_count = 0;
    int          last_pulse_cyc = 0;

    // Container stand-in: done falls one cycle after the reset pulse, rises done_delay cycles later.
    int done_delay = 5;
    int cd = -1;
    bit pend = 1'b0;
    initial begin
        container_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                cd = -1; pend = 1'b0; container_done = 1'b0;
            end else if (pend) begin
                pend = 1'b0; container_done = 1'b0; cd = done_delay;
            end else if (container_reset) begin
                pend = 1'b1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) container_done = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One scoreboard-tracked cycle; v/dmin/dmax govern the next edge's offer and the next run's done delay.
    task automatic step(input bit v, input int dmin, input int dmax);
        upd_t got;
        int   d;
        if (upd_valid && upd_ready) begin
            sb.push_back({upd_src, upd_dst, upd_e});
            acc_count++;
        end
        tick;
        cyc++;
        if (cyc == retire_at) exp_runs++;
        chk("run_count", {16'd0, run_count}, {16'd0, exp_runs});
        if (container_reset) begin
            pulse_count++;
            last_pulse_cyc = cyc;
            chk("pulse_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                chk("order_u_src", 32'(u_src), 32'(got.s));
                chk("order_u_dst", 32'(u_dst), 32'(got.d));
                chk("order_u_e", 32'(u_e), 32'(got.e));
            end
            chk("run_src", 32'(src), 32'(cfg_src));
            if (dmin < 0) begin
                done_delay = -1;
                retire_at  = -1;
            end else begin
                d = int'($urandom_range(dmax, dmin));
                done_delay = d;
                retire_at  = cyc + d + 3;
            end
        end
        upd_valid = v;
        upd_src   = PRED_W'($urandom);
        upd_dst   = PRED_W'($urandom);
        upd_e     = WEIGHT_W'($urandom);
    endtask

    task automatic wait_idle;
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
            step(1'b0, 2, 6);
        end
        chk("reached_idle", 32'(ok), 32'd1);
    endtask

    // Single run from idle: pulse 3 cycles after accept, retire d+3 cycles after the pulse.
    task automatic run_single(input row_t r);
        chk("row_idle", 32'(busy), 32'd0);
        done_delay = r.delay;
        if (r.preload) begin
            dut.run_cnt_q = 16'hFFFF;
            exp_runs = 16'hFFFF;
        end
        cfg_src = r.c; upd_src = r.s; upd_dst = r.d; upd_e = r.e; upd_valid = 1'b1;
        chk("row_ready", 32'(upd_ready), 32'd1);
        tick;
        upd_valid = 1'b0;
        tick; chk("crst_plus1", 32'(container_reset), 32'd0);
        tick; chk("crst_plus2", 32'(container_reset), 32'd0);
        tick; chk("crst_plus3", 32'(container_reset), 32'd1);
        chk("row_src", 32'(src), 32'(r.c));
        chk("row_u_src", 32'(u_src), 32'(r.s));
        chk("row_u_dst", 32'(u_dst), 32'(r.d));
        chk("row_u_e", 32'(u_e), 32'(r.e));
        chk("row_busy", 32'(busy), 32'd1);
        for (int j = 1; j <= r.delay + 2; j++) begin
            tick;
            if (j == 1) chk("crst_plus4", 32'(container_reset), 32'd0);
            if (j == r.delay + 2) chk("no_early_retire", 32'(run_count), 32'(exp_runs));
        end
        tick;
        exp_runs++;
        chk("row_run_count", 32'(run_count), 32'(r.exp_count));
        chk("row_model_count", 32'(run_count), 32'(exp_runs));
        chk("row_back_idle", 32'(busy), 32'd0);
        chk("row_operands_held", 32'(u_src), 32'(r.s));
    endtask

    row_t rows[5];
    int   p0, a0;

    initial begin
        rows[0] = '{s: 8'd2,   d: 8'd5,  c: 8'd0,   e: 16'd100,    delay: 20, preload: 1'b0, exp_count: 16'd1};
        rows[1] = '{s: 8'hFF,  d: 8'd0,  c: 8'd7,   e: 16'hFFFF,   delay: 1,  preload: 1'b0, exp_count: 16'd2};
        rows[2] = '{s: 8'd3,   d: 8'd4,  c: 8'd1,   e: 16'd9,      delay: 11, preload: 1'b0, exp_count: 16'd3};
        rows[3] = '{s: 8'h10,  d: 8'h20, c: 8'hAA,  e: 16'h1234,   delay: 5,  preload: 1'b1, exp_count: 16'd0};
        rows[4] = '{s: 8'd1,   d: 8'd1,  c: 8'd1,   e: 16'd1,      delay: 2,  preload: 1'b0, exp_count: 16'd1};

        reset = 1'b1; upd_valid = 1'b0; upd_src = '0; upd_dst = '0; upd_e = '0; cfg_src = '0;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        chk("rst_container_reset", 32'(container_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_run_count", 32'(run_count), 32'd0);
        chk("rst_operands", {src, u_src, u_dst, u_e[7:0]}, 32'd0);
        chk("rst_ready", 32'(upd_ready), 32'd1);

        // Directed runs (row 2 sees a stale done left from row 1; row 3 wraps the counter).
        for (int i = 0; i < 5; i++) run_single(rows[i]);

        // Burst of offers while the first run is long: 9 accepts, then full.
        cfg_src = 8'h3C;
        acc_count = 0;
        for (int i = 0; i < 13; i++) step(1'b1, 30, 30);
        chk("burst_accepts", 32'(acc_count), 32'd9);
        chk("burst_ready_low", 32'(upd_ready), 32'd0);
        wait_idle();
        chk("burst_runs_done", 32'(run_count), 32'(exp_runs));

        // Random offers and done delays against the scoreboard.
        cfg_src = PRED_W'($urandom);
        for (int i = 0; i < 600; i++) step($urandom_range(7, 0) == 0, 1, 25);
        wait_idle();
        chk("random_final_count", 32'(run_count), 32'(exp_runs));

        // Reset mid-WAIT with three entries still queued.
        for (int i = 0; i < 5; i++) step(i < 4, 40, 40);
        for (int i = 0; i < 3; i++) step(1'b0, 40, 40);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        exp_runs = 16'd0; sb.delete(); retire_at = -1;
        chk("async_container_reset", 32'(container_reset), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_run_count", 32'(run_count), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_operands", {src, u_src, u_dst, u_e[7:0]}, 32'd0);
        tick;
        reset = 1'b0;
        p0 = pulse_count;
        for (int i = 0; i < 10; i++) step(1'b0, 2, 6);
        chk("reset_queue_empty", 32'(pulse_count), 32'(p0));
        chk("reset_stays_idle", 32'(busy), 32'd0);

        // Timeout: done never comes; error at WAIT entry + TIMEOUT.
        p0 = pulse_count;
        step(1'b1, -1, -1);
        for (int i = 0; i < 10 && pulse_count == p0; i++) step(1'b0, -1, -1);
        chk("timeout_pulse_seen", 32'(pulse_count), 32'(p0 + 1));
        for (int i = 1; i <= 49; i++) step(i <= 2, -1, -1);
        chk("timeout_cycle", 32'(cyc), 32'(last_pulse_cyc + 49));
        chk("err_before_timeout", 32'(err), 32'd0);
        step(1'b0, -1, -1);
        chk("err_at_timeout", 32'(err), 32'd1);
        chk("ready_in_error", 32'(upd_ready), 32'd0);
        chk("busy_in_error", 32'(busy), 32'd1);
        p0 = pulse_count; a0 = acc_count;
        for (int i = 0; i < 10; i++) step(1'b1, -1, -1);
        chk("error_no_accepts", 32'(acc_count), 32'(a0));
        chk("error_no_pulses", 32'(pulse_count), 32'(p0));
        chk("err_sticky", 32'(err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
